// File: rtl/maze_pkg.sv
// Shared constants, tile-word layout, FSM encoding and shadow payload for maze_map_writer.
package maze_pkg;

  localparam int unsigned MAP_W     = 4;
  localparam int unsigned MAP_H     = 5;
  localparam int unsigned MAP_TILES = 20;

  localparam int unsigned X_W      = 2;
  localparam int unsigned Y_W      = 3;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned TILE_W   = 8;
  localparam int unsigned WALL_W   = 4;
  localparam int unsigned TRS_W    = 2;
  localparam int unsigned CNT_W    = 5;

  localparam int unsigned VIS_BIT  = 7;
  localparam int unsigned CUR_BIT  = 6;
  localparam int unsigned TRS_MSB  = 5;
  localparam int unsigned TRS_LSB  = 4;
  localparam int unsigned WALL_MSB = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLR_PREV = 2'd1,
    SET_CUR  = 2'd2,
    WR_INFO  = 2'd3
  } state_t;

  // Update payload latched on an accepted edge; the kind is carried by the FSM path.
  typedef struct packed {
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [WALL_W-1:0] walls;
    logic [TRS_W-1:0]  trs;
  } upd_t;

  function automatic logic [IDX_W-1:0] tile_idx(input logic [X_W-1:0] x,
                                                input logic [Y_W-1:0] y);
    return IDX_W'(IDX_W'(y) * IDX_W'(MAP_W) + IDX_W'(x));
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with rising-edge detect; a level already high when reset
// releases must first be seen low before any edge is reported.
module sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise_c
);

  logic       r_meta;
  logic       r_sync;
  logic       r_prev;
  logic       r_armed;
  logic [1:0] r_fill;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
      r_fill  <= 2'b00;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_fill <= {r_fill[0], 1'b1};
      // r_sync only carries a real sample once the chain has refilled after reset
      if (r_fill[1] && !r_sync) r_armed <= 1'b1;
    end
  end

  assign o_rise_c = r_armed & r_sync & ~r_prev;

endmodule

// File: rtl/maze_map_writer.sv
// 4x5 maze tile map writer driven by asynchronous position / tile-info update strobes.
// Optional visited-tile counter enabled by defining VISITED_COUNT_EN.
module maze_map_writer
  import maze_pkg::*;
(
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              upd_req,
  input  logic              upd_kind,
  input  logic [X_W-1:0]    pos_x,
  input  logic [Y_W-1:0]    pos_y,
  input  logic [WALL_W-1:0] walls,
  input  logic [TRS_W-1:0]  treasure,
  input  logic [X_W-1:0]    rd_x,
  input  logic [Y_W-1:0]    rd_y,
  output logic [TILE_W-1:0] rd_data,
  output logic              busy,
  output logic              err,
  output logic [CNT_W-1:0]  visited_cnt,
  output logic              map_done
);

  logic              w_edge;
  state_t            r_state;
  state_t            w_state_nxt;
  upd_t              r_shd;
  logic [TILE_W-1:0] r_map [MAP_TILES];
  logic [X_W-1:0]    r_cur_x;
  logic [Y_W-1:0]    r_cur_y;
  logic              r_cur_valid;
  logic              r_err;
  logic              r_busy;
  logic [TILE_W-1:0] r_rd_data;

  logic              w_accept;
  logic              w_err_set;
  logic              w_we;
  logic [IDX_W-1:0]  w_waddr;
  logic [TILE_W-1:0] w_wdata;
  logic [IDX_W-1:0]  w_cur_idx;
  logic [IDX_W-1:0]  w_new_idx;

  sync_edge u_sync_edge (
    .i_clk    (CLOCK_50),
    .i_rst    (reset),
    .i_async  (upd_req),
    .o_rise_c (w_edge)
  );

  assign w_cur_idx = tile_idx(r_cur_x, r_cur_y);
  assign w_new_idx = tile_idx(r_shd.x, r_shd.y);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  // Next state, acceptance/error decisions and the single map write port.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_err_set   = 1'b0;
    w_we        = 1'b0;
    w_waddr     = w_cur_idx;
    w_wdata     = r_map[w_cur_idx];

    if (w_edge && (r_state != IDLE)) w_err_set = 1'b1;

    case (r_state)
      IDLE: begin
        if (w_edge) begin
          if (upd_kind) begin
            if (pos_y < Y_W'(MAP_H)) begin
              w_accept    = 1'b1;
              w_state_nxt = CLR_PREV;
            end else begin
              w_err_set = 1'b1;
            end
          end else if (r_cur_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = WR_INFO;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      CLR_PREV: begin
        w_we        = r_cur_valid;
        w_wdata     = r_map[w_cur_idx] & ~(TILE_W'(1) << CUR_BIT);
        w_state_nxt = SET_CUR;
      end
      SET_CUR: begin
        w_we        = 1'b1;
        w_waddr     = w_new_idx;
        w_wdata     = r_map[w_new_idx] | (TILE_W'(1) << VIS_BIT) | (TILE_W'(1) << CUR_BIT);
        w_state_nxt = IDLE;
      end
      WR_INFO: begin
        w_we        = 1'b1;
        w_wdata     = {r_map[w_cur_idx][VIS_BIT:CUR_BIT], r_shd.trs, r_shd.walls};
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_shd       <= '0;
      r_cur_x     <= '0;
      r_cur_y     <= '0;
      r_cur_valid <= 1'b0;
      r_err       <= 1'b0;
      r_rd_data   <= '0;
      for (int unsigned i = 0; i < MAP_TILES; i++) r_map[i] <= '0;
    end else begin
      if (w_accept) r_shd <= '{x: pos_x, y: pos_y, walls: walls, trs: treasure};
      if (w_err_set) r_err <= 1'b1;
      if (w_we) r_map[w_waddr] <= w_wdata;
      if (r_state == SET_CUR) begin
        r_cur_x     <= r_shd.x;
        r_cur_y     <= r_shd.y;
        r_cur_valid <= 1'b1;
      end
      // Old map contents are sampled, so a same-cycle write is not visible yet
      if (rd_y < Y_W'(MAP_H)) r_rd_data <= r_map[tile_idx(rd_x, rd_y)];
      else                    r_rd_data <= '0;
    end
  end

  assign rd_data = r_rd_data;
  assign busy    = r_busy;
  assign err     = r_err;

`ifdef VISITED_COUNT_EN
  logic             w_vis_new;
  logic [CNT_W-1:0] r_visited_cnt;
  logic             r_map_done;

  assign w_vis_new = (r_state == SET_CUR) && !r_map[w_new_idx][VIS_BIT];

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_visited_cnt <= '0;
      r_map_done    <= 1'b0;
    end else if (w_vis_new && (r_visited_cnt < CNT_W'(MAP_TILES))) begin
      r_visited_cnt <= r_visited_cnt + CNT_W'(1);
      r_map_done    <= ((r_visited_cnt + CNT_W'(1)) == CNT_W'(MAP_TILES));
    end
  end

  assign visited_cnt = r_visited_cnt;
  assign map_done    = r_map_done;
`else
  assign visited_cnt = '0;
  assign map_done    = 1'b0;
`endif

endmodule

// File: tb/tb_maze_map_writer.sv
// Randomized self-checking bench for maze_map_writer against a tile-array reference model.
module tb_maze_map_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       upd_req;
  logic       upd_kind;
  logic [1:0] pos_x;
  logic [2:0] pos_y;
  logic [3:0] walls;
  logic [1:0] treasure;
  logic [1:0] rd_x;
  logic [2:0] rd_y;
  logic [7:0] rd_data;
  logic       busy;
  logic       err;
  logic [4:0] visited_cnt;
  logic       map_done;

  always #5 clk = ~clk;

  maze_map_writer dut (
    .CLOCK_50    (clk),
    .reset       (rst),
    .upd_req     (upd_req),
    .upd_kind    (upd_kind),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .walls       (walls),
    .treasure    (treasure),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .rd_data     (rd_data),
    .busy        (busy),
    .err         (err),
    .visited_cnt (visited_cnt),
    .map_done    (map_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain tile array plus current-position bookkeeping.
  logic [7:0] m [20];
  int         cx, cy, mcnt;
  bit         cvalid, merr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 20; i++) m[i] = 8'h00;
    cx = 0; cy = 0; mcnt = 0; cvalid = 0; merr = 0;
  endfunction

  // Applies one update; returns the number of busy cycles it should cause.
  function automatic int model_apply(bit kind, int x, int y, logic [3:0] w, logic [1:0] t);
    int idx;
    if (kind) begin
      if (y > 4) begin merr = 1; return 0; end
      idx = y * 4 + x;
      if (cvalid) m[cy * 4 + cx][6] = 1'b0;
      if (!m[idx][7] && mcnt < 20) mcnt++;
      m[idx] = m[idx] | 8'hC0;
      cx = x; cy = y; cvalid = 1;
      return 2;
    end
    if (!cvalid) begin merr = 1; return 0; end
    idx = cy * 4 + cx;
    m[idx] = {m[idx][7:6], t, w};
    return 1;
  endfunction

  function automatic int exp_cnt();
`ifdef VISITED_COUNT_EN
    return mcnt;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic read_tile(input int x, input int y, output logic [7:0] d);
    rd_x = 2'(x);
    rd_y = 3'(y);
    tick();
    d = rd_data;
  endtask

  task automatic check_map(input string tag);
    logic [7:0] d;
    for (int i = 0; i < 20; i++) begin
      read_tile(i % 4, i / 4, d);
      check($sformatf("%s_tile%0d", tag, i), d, m[i]);
    end
    check({tag, "_err"}, err, merr);
    check({tag, "_cnt"}, visited_cnt, exp_cnt());
    check({tag, "_done"}, map_done, exp_cnt() == 20);
  endtask

  task automatic set_inputs(input bit kind, input int x, input int y,
                            input logic [3:0] w, input logic [1:0] t);
    upd_kind = kind; pos_x = 2'(x); pos_y = 3'(y); walls = w; treasure = t;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    repeat (4) tick();
  endtask

  task automatic do_update(input bit kind, input int x, input int y,
                           input logic [3:0] w, input logic [1:0] t);
    int bc = 0;
    int exp;
    set_inputs(kind, x, y, w, t);
    repeat (3) tick();
    upd_req = 1'b1;
    repeat (10) begin tick(); if (busy) bc++; end
    upd_req = 1'b0;
    repeat (4) tick();
    exp = model_apply(kind, x, y, w, t);
    check("busy_cycles", bc, exp);
  endtask

  initial begin
    logic [7:0] d;
    int bc;
    bit got_busy;
    rst = 1'b1; upd_req = 1'b0; rd_x = '0; rd_y = '0;
    set_inputs(0, 0, 0, 4'h0, 2'h0);
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
    check("reset_busy", busy, 0);
    check_map("reset");

    // Directed scenarios
    do_update(1, 1, 2, 4'h0, 2'h0);
    check_map("pos12");
    do_update(1, 2, 2, 4'h0, 2'h0);
    check_map("pos22");
    do_update(1, 0, 0, 4'h0, 2'h0);
    do_update(0, 0, 0, 4'b1010, 2'b01);
    check_map("info00");
    do_update(1, 0, 0, 4'h0, 2'h0);
    check_map("same_tile");

    do_reset();
    do_update(0, 3, 3, 4'hF, 2'h3);
    check_map("info_no_cur");
    do_reset();
    do_update(1, 1, 5, 4'h0, 2'h0);
    check_map("bad_y");

    // Second edge two cycles after the first lands while busy
    do_reset();
    set_inputs(1, 3, 1, 4'h0, 2'h0);
    repeat (3) tick();
    upd_req = 1'b1; tick();
    upd_req = 1'b0; tick();
    upd_req = 1'b1;
    bc = 0;
    repeat (10) begin tick(); if (busy) bc++; end
    upd_req = 1'b0;
    repeat (4) tick();
    check("collide_busy", bc, model_apply(1, 3, 1, 4'h0, 2'h0));
    merr = 1;
    check_map("collide");

    // Reset asserted while SET_CUR is in flight
    do_update(1, 2, 4, 4'h0, 2'h0);
    set_inputs(1, 0, 3, 4'h0, 2'h0);
    repeat (3) tick();
    upd_req = 1'b1;
    got_busy = 0;
    for (int i = 0; i < 10 && !got_busy; i++) begin tick(); got_busy = busy; end
    check("midreset_busy_seen", got_busy, 1);
    tick();
    rst = 1'b1;
    tick();
    check("midreset_busy", busy, 0);
    rst = 1'b0;
    upd_req = 1'b0;
    model_reset();
    repeat (4) tick();
    check_map("midreset");

    // Randomized updates
    for (int n = 0; n < 80; n++) begin
      do_update(($urandom % 3) != 0, $urandom_range(0, 3), $urandom_range(0, 5),
                4'($urandom), 2'($urandom));
      if (n % 20 == 19) check_map($sformatf("rand%0d", n));
    end

    // Visit every tile, then revisit one
    do_reset();
    for (int i = 0; i < 20; i++) do_update(1, i % 4, i / 4, 4'h0, 2'h0);
    check_map("all_visited");
    do_update(1, 2, 1, 4'h0, 2'h0);
    do_update(0, 2, 1, 4'h5, 2'h2);
    check_map("revisit");
    for (int y = 5; y < 8; y++) begin
      read_tile(1, y, d);
      check($sformatf("rd_y%0d", y), d, 8'h00);
    end

    // upd_req already high across reset release must not trigger
    set_inputs(1, 1, 1, 4'h0, 2'h0);
    upd_req = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    bc = 0;
    repeat (12) begin tick(); if (busy) bc++; end
    check("held_req_busy", bc, 0);
    upd_req = 1'b0;
    repeat (4) tick();
    check_map("held_req");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
